dff_bank_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one bank of D-flip-flop registers among several requesters. Each requester issues single-word read or write transactions with a req/ack handshake. The block serialises them through a 3-state FSM and drives the bank's write enable and read capture. It sits between the requester logic and the gate-level flip-flop storage, and is the only writer of that storage.

---
 rtl/dff_bank_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/dff_bank_arbiter.sv | 135 +++++++++++++
 tb/tb_dff_bank_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dff_bank_pkg.sv
// Shared types and default sizes for the shared flip-flop bank sequencer.
// Latency: none, declarations only.
// Backpressure: not applicable.
package dff_bank_pkg;

    // Sequencer states; encodings are fixed so they stay stable in waveforms.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; losers simply stay unselected.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int PW   = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found;

    // Walk the requesters starting at ptr and keep the first hit.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            int cand;
            cand = (int'(ptr) + off) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Serialises single-word reads/writes from N_REQ requesters onto one register bank.
// Latency: 3 cycles per transaction (latch, access, ack); one transaction every 3 cycles.
// Backpressure: requesters hold req until their one-cycle ack; losers wait in place.
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*$clog2(DEPTH)-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [DEPTH*DATA_W-1:0]   q
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = $clog2(N_REQ);

    state_t              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    win_q;
    logic [N_REQ-1:0]    gnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [N_REQ-1:0]    ack_q;
    logic                busy_q;
    logic [DATA_W-1:0]   bank_q [DEPTH];

    logic [N_REQ-1:0]    arb_gnt;
    logic [PTR_W-1:0]    arb_idx;
    logic                sel_we_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [DATA_W-1:0]   sel_wdata_d;
    logic [PTR_W-1:0]    ptr_d;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Pull the winner's operation out of the flattened request buses.
    always_comb begin
        sel_we_d    = we[arb_idx];
        sel_addr_d  = addr[int'(arb_idx)*ADDR_W +: ADDR_W];
        sel_wdata_d = wdata[int'(arb_idx)*DATA_W +: DATA_W];
        ptr_d       = PTR_W'((int'(win_q) + 1) % N_REQ);
    end

    // Sequencer: latch the winner in IDLE, touch the bank in ACCESS, ack in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= '0;
                    if (|req) begin
                        win_q   <= arb_idx;
                        gnt_q   <= arb_gnt;
                        we_q    <= sel_we_d;
                        addr_q  <= sel_addr_d;
                        wdata_q <= sel_wdata_d;
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Writes leave rdata_q alone so the last read value persists.
                    if (!we_q) begin
                        rdata_q <= bank_q[addr_q];
                    end
                    ack_q   <= gnt_q;
                    state_q <= DONE;
                end
                DONE: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Register bank: written only in ACCESS, so reset on that edge discards the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                bank_q[k] <= '0;
            end
        end else if (state_q == ACCESS && we_q) begin
            bank_q[addr_q] <= wdata_q;
        end
    end

    genvar gk;
    generate
        for (gk = 0; gk < DEPTH; gk++) begin : g_q
            assign q[gk*DATA_W +: DATA_W] = bank_q[gk];
        end
    endgenerate

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for the shared register bank sequencer.
// Latency: expects ack in the third cycle after req and 3 cycles between acks.
// Backpressure: requesters hold req until ack, then drop it.
module tb_dff_bank_arbiter;
    import dff_bank_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [31:0] q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dff_bank_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW),
        .DEPTH  (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .busy  (busy),
        .q     (q)
    );

    // Step negedges until any ack appears or the budget runs out (a stays 0).
    task automatic wait_ack(input int budget, output int cyc, output logic [3:0] a);
        cyc = 0;
        a   = 4'b0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack !== 4'b0) begin
                a = ack;
                break;
            end
        end
    endtask

    task automatic drop_all();
        req = 4'b0;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic w, input logic [1:0] ad, input logic [7:0] d);
        req[i]               = 1'b1;
        we[i]                = w;
        addr[i*AW +: AW]     = ad;
        wdata[i*DW +: DW]    = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            req   = 4'($urandom);
            we    = 4'($urandom);
            addr  = 8'($urandom);
            wdata = $urandom;
            @(negedge clk);
            checks++;
            if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
            checks++;
            if (q !== 32'h0) begin errors++; $display("FAIL reset_q: got %h expected 00000000", q); end
            checks++;
            if (rdata !== 8'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        end
        rst = 1'b0;
        req = 4'b0;
        @(negedge clk);
        checks++;
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
        checks++;
        if (ack !== 4'b0) begin errors++; $display("FAIL reset_idle_ack: got %b expected 0000", ack); end
    endtask

    task automatic test_single_write_read();
        int cyc;
        logic [3:0] a;
        set_req(2, 1'b1, 2'd1, 8'hA5);
        wait_ack(10, cyc, a);
        checks++;
        if (a !== 4'b0100) begin errors++; $display("FAIL wr_ack: got %b expected 0100", a); end
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", cyc); end
        checks++;
        if (q[15:8] !== 8'hA5) begin errors++; $display("FAIL wr_q1: got %h expected a5", q[15:8]); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b expected 1", busy); end
        drop_all();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle_busy: got %b expected 0", busy); end
        set_req(2, 1'b0, 2'd1, 8'h00);
        wait_ack(10, cyc, a);
        checks++;
        if (a !== 4'b0100) begin errors++; $display("FAIL rd_ack: got %b expected 0100", a); end
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", cyc); end
        checks++;
        if (rdata !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h expected a5", rdata); end
        drop_all();
    endtask

    task automatic test_contention();
        int cyc;
        logic [3:0] a;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_a;
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        req  = 4'b1111;
        we   = 4'b0000;
        addr = 8'h00;
        for (int i = 0; i < 5; i++) begin
            exp_a = 4'b0001 << order[i];
            wait_ack(12, cyc, a);
            checks++;
            if (a !== exp_a) begin errors++; $display("FAIL cont_order[%0d]: got %b expected %b", i, a, exp_a); end
            checks++;
            if (cyc !== ((i == 0) ? 2 : 3)) begin errors++; $display("FAIL cont_spacing[%0d]: got %0d expected %0d", i, cyc, (i == 0) ? 2 : 3); end
        end
        checks++;
        if (rdata !== 8'h00) begin errors++; $display("FAIL cont_rdata: got %h expected 00", rdata); end
        drop_all();
    endtask

    task automatic test_fairness();
        int cyc;
        logic [3:0] a;
        set_req(3, 1'b1, 2'd2, 8'h5A);
        wait_ack(10, cyc, a);
        checks++;
        if (a !== 4'b1000) begin errors++; $display("FAIL fair_serve3: got %b expected 1000", a); end
        drop_all();
        set_req(1, 1'b0, 2'd2, 8'h00);
        set_req(3, 1'b0, 2'd2, 8'h00);
        wait_ack(10, cyc, a);
        checks++;
        if (a !== 4'b0010) begin errors++; $display("FAIL fair_first: got %b expected 0010", a); end
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL fair_first_lat: got %0d expected 2", cyc); end
        req[1] = 1'b0;
        wait_ack(10, cyc, a);
        checks++;
        if (a !== 4'b1000) begin errors++; $display("FAIL fair_second: got %b expected 1000", a); end
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL fair_second_lat: got %0d expected 3", cyc); end
        checks++;
        if (rdata !== 8'h5A) begin errors++; $display("FAIL fair_rdata: got %h expected 5a", rdata); end
        checks++;
        if (q[23:16] !== 8'h5A) begin errors++; $display("FAIL fair_q2: got %h expected 5a", q[23:16]); end
        drop_all();
    endtask

    task automatic test_read_after_write();
        int cyc;
        logic [3:0] a;
        set_req(0, 1'b1, 2'd3, 8'h3C);
        set_req(1, 1'b0, 2'd3, 8'h00);
        wait_ack(10, cyc, a);
        checks++;
        if (a !== 4'b0001) begin errors++; $display("FAIL raw_wr_ack: got %b expected 0001", a); end
        req[0] = 1'b0;
        wait_ack(10, cyc, a);
        checks++;
        if (a !== 4'b0010) begin errors++; $display("FAIL raw_rd_ack: got %b expected 0010", a); end
        checks++;
        if (rdata !== 8'h3C) begin errors++; $display("FAIL raw_rdata: got %h expected 3c", rdata); end
        checks++;
        if (q[31:24] !== 8'h3C) begin errors++; $display("FAIL raw_q3: got %h expected 3c", q[31:24]); end
        drop_all();
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [3:0] a;
        set_req(0, 1'b1, 2'd0, 8'hFF);
        @(negedge clk);
        checks++;
        if (dut.state_q !== ACCESS) begin errors++; $display("FAIL mid_in_access: got %0d expected %0d", dut.state_q, ACCESS); end
        rst = 1'b1;
        req = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ack !== 4'b0) begin errors++; $display("FAIL mid_ack: got %b expected 0000", ack); end
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL mid_q: got %h expected 00000000", q); end
        checks++;
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL mid_state: got %0d expected %0d", dut.state_q, IDLE); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        wait_ack(6, cyc, a);
        checks++;
        if (a !== 4'b0) begin errors++; $display("FAIL mid_late_ack: got %b expected 0000", a); end
        checks++;
        if (q[7:0] !== 8'h00) begin errors++; $display("FAIL mid_q0: got %h expected 00", q[7:0]); end
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b0;
        we    = 4'b0;
        addr  = 8'h0;
        wdata = 32'h0;
        test_reset();
        test_single_write_read();
        test_contention();
        test_fairness();
        test_read_after_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
